// File: rtl/wb_dma_fifo_pkg.sv
// Shared definitions for the DMA-fed stream FIFO slave: register map, bit
// positions and the DMA handshake state type.
package wb_dma_fifo_pkg;

  // Word offsets decoded from ADR[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_SPARE  = 2'd3;

  // STATUS bit positions (level occupies [7:0])
  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_OVF   = 10;
  localparam int STAT_LAST  = 11;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_THR_LSB = 1;
  localparam int CTRL_THR_MSB = 7;
  localparam int CTRL_OVF_IE  = 8;
  localparam int CTRL_CLR     = 9;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } dma_state_e;

  // A zero threshold would never fire sensibly, and one above the FIFO depth
  // could never be reached, so both are pulled into the usable range.
  function automatic logic [7:0] clamp_thr(input logic [6:0] thr, input logic [7:0] depth);
    logic [7:0] t;
    t = {1'b0, thr};
    if (t == 8'd0) begin
      return 8'd1;
    end else if (t > depth) begin
      return depth;
    end else begin
      return t;
    end
  endfunction

endpackage

// File: rtl/wb_if.sv
// Minimal 32-bit Wishbone bundle with master and slave views.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport slave (
    input  cyc, stb, we, adr, sel, wdata,
    output rdata, ack, err
  );

  modport master (
    output cyc, stb, we, adr, sel, wdata,
    input  rdata, ack, err
  );
endinterface

// File: rtl/wb_dma_sfifo.sv
// Synchronous FIFO with push, pop and flush. The head word is presented
// combinationally; a push into a full FIFO is accepted only alongside a pop.
module wb_dma_sfifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array; no reset needed since occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_dma_fifo_slv.sv
// Wishbone slave that buffers an inbound word stream and asks a wb_dma
// channel to drain it once a programmable watermark is reached. The final
// partial chunk of a packet is flagged to the DMA via dma_nd_o.
module wb_dma_fifo_slv
  import wb_dma_fifo_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DEF_THR = 4
) (
  input  logic        clk,
  input  logic        rst_i,
  wb_if.slave         wbs,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic        dma_req_o,
  output logic        dma_nd_o,
  input  logic        dma_ack_i,
  output logic        irq_o
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic [31:0]   head;

  logic [1:0]    reg_sel;
  logic          access;
  logic          acc_err;
  logic          pop;
  logic          push;
  logic          drop;
  logic          ctrl_wr;
  logic          status_wr;
  logic          clr;
  logic          ovf_clr;

  logic          en;
  logic [6:0]    thr;
  logic          ovf_ie;
  logic          ovf;
  logic          last_pend;

  logic [7:0]    level8;
  logic [7:0]    thr_eff;
  logic          start;
  logic          short_chunk;
  logic          nd_next;
  dma_state_e    state;
  dma_state_e    state_next;
  logic [31:0]   read_mux;
  logic          unused_bits;

  assign reg_sel   = wbs.adr[3:2];
  assign access    = wbs.cyc & wbs.stb & ~wbs.ack & ~wbs.err;
  assign acc_err   = access & (reg_sel == REG_DATA) & (wbs.we | empty);
  assign pop       = access & ~wbs.we & (reg_sel == REG_DATA) & ~empty;
  assign push      = in_valid_i & (~full | pop);
  assign drop      = in_valid_i & full & ~pop;
  assign ctrl_wr   = access & wbs.we & (reg_sel == REG_CTRL);
  assign status_wr = access & wbs.we & (reg_sel == REG_STATUS);
  assign clr       = ctrl_wr & wbs.wdata[CTRL_CLR];
  assign ovf_clr   = status_wr & wbs.wdata[STAT_OVF];

  assign unused_bits = ^{wbs.sel, wbs.adr[31:4], wbs.adr[1:0], wbs.wdata[31:11]};

  wb_dma_sfifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (clr),
    .wdata (in_data_i),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign level8      = 8'(level);
  assign thr_eff     = clamp_thr(thr, 8'(DEPTH));
  assign start       = en & ((level8 >= thr_eff) | (last_pend & ~empty));
  assign short_chunk = (level8 < thr_eff);

  assign in_ready_o = ~full;
  assign dma_req_o  = (state == REQ);
  assign irq_o      = ovf & ovf_ie;

  // Control register, sticky overflow flag and end-of-packet tracking
  always_ff @(posedge clk) begin
    if (rst_i) begin
      en        <= 1'b0;
      thr       <= 7'(DEF_THR);
      ovf_ie    <= 1'b0;
      ovf       <= 1'b0;
      last_pend <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en     <= wbs.wdata[CTRL_EN];
        thr    <= wbs.wdata[CTRL_THR_MSB:CTRL_THR_LSB];
        ovf_ie <= wbs.wdata[CTRL_OVF_IE];
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (clr) begin
        last_pend <= 1'b0;
      end else if (push && in_last_i) begin
        last_pend <= 1'b1;
      end else if (pop && !push && (level8 == 8'd1)) begin
        last_pend <= 1'b0;
      end
    end
  end

  // Register read multiplexer; head word is captured before the pop lands
  always_comb begin
    read_mux = '0;
    case (reg_sel)
      REG_DATA: read_mux = head;
      REG_STATUS: begin
        read_mux[7:0]      = level8;
        read_mux[STAT_EMPTY] = empty;
        read_mux[STAT_FULL]  = full;
        read_mux[STAT_OVF]   = ovf;
        read_mux[STAT_LAST]  = last_pend;
      end
      REG_CTRL: begin
        read_mux[CTRL_EN]                   = en;
        read_mux[CTRL_THR_MSB:CTRL_THR_LSB] = thr;
        read_mux[CTRL_OVF_IE]               = ovf_ie;
      end
      REG_SPARE: read_mux = '0;
      default:   read_mux = '0;
    endcase
  end

  // Single-cycle Wishbone termination, exactly one of ACK or ERR per access
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wbs.ack   <= 1'b0;
      wbs.err   <= 1'b0;
      wbs.rdata <= '0;
    end else begin
      wbs.ack <= access & ~acc_err;
      wbs.err <= acc_err;
      if (access && !wbs.we && !acc_err) begin
        wbs.rdata <= read_mux;
      end
    end
  end

  // DMA handshake state register and registered short-chunk marker
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state    <= IDLE;
      dma_nd_o <= 1'b0;
    end else begin
      state    <= state_next;
      dma_nd_o <= nd_next;
    end
  end

  // Request sequencing; HOLD guarantees one low cycle after each ack
  always_comb begin
    state_next = state;
    nd_next    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          nd_next    = short_chunk;
        end
      end
      REQ: begin
        if (!en) begin
          state_next = IDLE;
        end else if (dma_ack_i) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (start) begin
          state_next = REQ;
          nd_next    = short_chunk;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (clr) begin
      state_next = IDLE;
      nd_next    = 1'b0;
    end
  end

endmodule
